// File: rtl/axis_pkg.sv
// Shared definitions for the stream-to-memory AXI stages: one-hot state indices,
// the default burst size and the element-to-beat rounding used by both address and data stages.
package axis_pkg;

  localparam int NUM_STATES = 5;
  localparam int IDLE   = 0;
  localparam int SETUP  = 1;
  localparam int ACTIVE = 2;
  localparam int WAITB  = 3;
  localparam int DONE   = 4;

  localparam int AXI_LEN_WIDTH_DEFAULT = 8;
  localparam int BURST_LENGTH          = 1 << AXI_LEN_WIDTH_DEFAULT;

  // Beats needed for a length in stream elements; the sum wraps at 'width' bits so
  // both stages see the same result for lengths near the top of the range.
  function automatic logic [63:0] round_beats(input logic [63:0] length,
                                              input int shift, input int width);
    logic [63:0] mask;
    logic [63:0] sum;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    sum  = (length + (64'd1 << shift) - 64'd1) & mask;
    return sum >> shift;
  endfunction

endpackage

// File: rtl/axis_wdata.sv
// AXI W-channel stage: forwards packed words and marks burst boundaries with wlast.
// Optional B-response tracking and resp_err port are enabled by AXIS_WDATA_BRESP_EN.
module axis_wdata
  import axis_pkg::*;
#(
  parameter int CFG_DWIDTH     = 32,
  parameter int CONVERT_SHIFT  = 3,
  parameter int AXI_LEN_WIDTH  = AXI_LEN_WIDTH_DEFAULT,
  parameter int AXI_DATA_WIDTH = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CFG_DWIDTH-1:0]       cfg_length,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   data,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic                        done
`ifdef AXIS_WDATA_BRESP_EN
  ,
  output logic                        resp_err
`endif
);

  localparam logic [NUM_STATES-1:0] S_IDLE   = NUM_STATES'(1) << IDLE;
  localparam logic [NUM_STATES-1:0] S_SETUP  = NUM_STATES'(1) << SETUP;
  localparam logic [NUM_STATES-1:0] S_ACTIVE = NUM_STATES'(1) << ACTIVE;
  localparam logic [NUM_STATES-1:0] S_WAITB  = NUM_STATES'(1) << WAITB;
  localparam logic [NUM_STATES-1:0] S_DONE   = NUM_STATES'(1) << DONE;

  logic [NUM_STATES-1:0]    state;
  logic [CFG_DWIDTH-1:0]    beats;
  logic [CFG_DWIDTH-1:0]    remain;
  logic [AXI_LEN_WIDTH-1:0] burst_cnt;
  logic                     fire;
  logic                     last_beat;
  logic                     wait_done;

  // Word path is a pure passthrough so a stalled beat holds exactly what upstream holds.
  assign fire       = state[ACTIVE] & data_valid & axi_wready;
  assign last_beat  = (&burst_cnt) | (remain == CFG_DWIDTH'(1));
  assign axi_wvalid = state[ACTIVE] & data_valid;
  assign data_ready = state[ACTIVE] & axi_wready;
  assign axi_wlast  = state[ACTIVE] & last_beat;
  assign axi_wdata  = data;
  assign axi_wstrb  = '1;
  assign cfg_ready  = state[IDLE];
  assign done       = state[DONE];

`ifdef AXIS_WDATA_BRESP_EN
  logic [CFG_DWIDTH-1:0] bursts;
  logic [CFG_DWIDTH-1:0] b_cnt;
  logic                  b_fire;

  assign axi_bready = state[ACTIVE] | state[WAITB];
  assign b_fire     = axi_bvalid & axi_bready;
  assign wait_done  = (b_cnt == bursts);

  always_ff @(posedge clk) begin
    if (rst) begin
      bursts   <= '0;
      b_cnt    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (state[IDLE] && cfg_valid) resp_err <= 1'b0;
      if (state[SETUP]) begin
        bursts <= (beats >> AXI_LEN_WIDTH) + CFG_DWIDTH'(|beats[AXI_LEN_WIDTH-1:0]);
        b_cnt  <= '0;
      end else if (b_fire) begin
        b_cnt <= b_cnt + CFG_DWIDTH'(1);
        if (axi_bresp != 2'b00) resp_err <= 1'b1;
      end
    end
  end
`else
  logic unused_b;

  assign axi_bready = 1'b1;
  assign wait_done  = 1'b1;
  assign unused_b   = ^{axi_bresp, axi_bvalid};
`endif

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beats     <= '0;
      remain    <= '0;
      burst_cnt <= '0;
    end else begin
      if (state[IDLE]) begin
        if (cfg_valid) begin
          beats <= CFG_DWIDTH'(round_beats(64'(cfg_length), CONVERT_SHIFT, CFG_DWIDTH));
          state <= S_SETUP;
        end
      end
      if (state[SETUP]) begin
        remain    <= beats;
        burst_cnt <= '0;
        state     <= (beats == '0) ? S_DONE : S_ACTIVE;
      end
      if (state[ACTIVE] && fire) begin
        remain    <= remain - CFG_DWIDTH'(1);
        burst_cnt <= last_beat ? '0 : burst_cnt + AXI_LEN_WIDTH'(1);
        if (remain == CFG_DWIDTH'(1)) state <= S_WAITB;
      end
      if (state[WAITB] && wait_done) state <= S_DONE;
      if (state[DONE]) state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_axis_wdata.sv
// Scoreboard bench for axis_wdata: expected beats are queued when a run is configured
// and popped as the W channel hands them over; also exercises B responses and mid-run reset.
module tb_axis_wdata;
  import axis_pkg::*;

  localparam int DW = 256;

  logic            clk;
  logic            rst;
  logic [31:0]     cfg_length;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [DW-1:0]   data;
  logic            data_valid;
  logic            data_ready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;
  logic            done;
`ifdef AXIS_WDATA_BRESP_EN
  logic            resp_err;
`endif

  axis_wdata dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .done(done)
`ifdef AXIS_WDATA_BRESP_EN
    , .resp_err(resp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t       exp_q[$];
  logic [1:0]  bresp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          fired, wvalid_cnt, wlast_cnt, done_cnt, last_fire_cyc, done_cyc;
  int          b_pending;
  logic        b_hs;
  logic        prev_stall;
  logic [DW-1:0] prev_data;
  beat_t       mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int run_id, input int idx);
    return {8{run_id[15:0], idx[15:0]}};
  endfunction

  // Monitor and B responder, sampled mid-cycle once the negedge drive has settled.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_stall = 1'b0;
      b_pending  = 0;
      b_hs       = 1'b0;
      axi_bvalid = 1'b0;
    end else begin
      if (b_hs) begin
        axi_bvalid = 1'b0;
        b_hs       = 1'b0;
      end
      if (!axi_bvalid && b_pending > 0) begin
        axi_bvalid = 1'b1;
        axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        b_pending--;
      end
      if (axi_bvalid && axi_bready) b_hs = 1'b1;

      if (prev_stall) begin
        check("wvalid_hold", DW'(axi_wvalid), DW'(1'b1));
        check("wdata_stable", axi_wdata, prev_data);
      end
      if (axi_wvalid) wvalid_cnt++;
      if (axi_wvalid && axi_wready) begin
        fired++;
        last_fire_cyc = cyc;
        check("beat_expected", DW'(exp_q.size() != 0), DW'(1'b1));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wdata", axi_wdata, mon_e.data);
          check("wlast", DW'(axi_wlast), DW'(mon_e.last));
          check("wstrb", DW'(axi_wstrb), DW'({(DW/8){1'b1}}));
        end
        if (axi_wlast) begin
          wlast_cnt++;
          b_pending++;
        end
      end
      prev_stall = axi_wvalid & ~axi_wready;
      prev_data  = axi_wdata;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Called just after a negedge; returns just after a negedge.
  task automatic send_words(input int run_id, input int n, input bit rnd, input bit gaps,
                            input int abort_at);
    int budget;
    for (int i = 0; i < n; i++) begin
      if (abort_at > 0 && i == abort_at) begin
        data_valid = 1'b0;
        return;
      end
      if (gaps) begin
        data_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          @(negedge clk);
        end
      end
      data       = word(run_id, i);
      data_valid = 1'b1;
      budget     = 0;
      forever begin
        axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (data_ready) break;
        @(negedge clk);
        budget++;
        if (budget > 2000) begin
          check("word_accept", DW'(data_ready), DW'(1'b1));
          data_valid = 1'b0;
          return;
        end
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic run(input int len, input int run_id, input bit rnd, input bit gaps,
                     input bit exp_err);
    logic [31:0] b32;
    int beats, exp_last, t, accept_cyc;
    b32      = 32'(len) + 32'd7;
    beats    = int'(b32 >> 3);
    exp_last = 0;
    for (int i = 0; i < beats; i++) begin
      beat_t b;
      b.data = word(run_id, i);
      b.last = ((i % BURST_LENGTH) == BURST_LENGTH - 1) || (i == beats - 1);
      if (b.last) exp_last++;
      exp_q.push_back(b);
    end
    fired = 0; wvalid_cnt = 0; wlast_cnt = 0; done_cnt = 0;
    check("cfg_ready_idle", DW'(cfg_ready), DW'(1'b1));
    cfg_length = 32'(len);
    cfg_valid  = 1'b1;
    accept_cyc = cyc;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    check("cfg_ready_busy", DW'(cfg_ready), DW'(1'b0));
`ifdef AXIS_WDATA_BRESP_EN
    check("resp_err_cleared", DW'(resp_err), DW'(1'b0));
`endif
    @(negedge clk);
    send_words(run_id, beats, rnd, gaps, 0);
    axi_wready = 1'b1;
    t = 0;
    while (done_cnt == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", DW'(done_cnt), DW'(1));
    check("beat_count", DW'(fired), DW'(beats));
    check("wlast_count", DW'(wlast_cnt), DW'(exp_last));
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    check("cfg_ready_back", DW'(cfg_ready), DW'(1'b1));
    if (!rnd && !gaps) check("wvalid_cycles", DW'(wvalid_cnt), DW'(beats));
    if (beats == 0) check("zero_done_latency", DW'(done_cyc - accept_cyc), DW'(2));
`ifdef AXIS_WDATA_BRESP_EN
    check("resp_err_final", DW'(resp_err), DW'(exp_err));
`else
    if (beats > 0) check("done_latency", DW'(done_cyc - last_fire_cyc), DW'(2));
    if (exp_err) check("resp_err_unused", DW'(1'b0), DW'(1'b0));
`endif
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_length = '0; data = '0;
    data_valid = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", DW'(cfg_ready), DW'(1'b1));
    check("rst_wvalid", DW'(axi_wvalid), DW'(1'b0));
    check("rst_data_ready", DW'(data_ready), DW'(1'b0));
    check("rst_wlast", DW'(axi_wlast), DW'(1'b0));
    check("rst_done", DW'(done), DW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;

    run(16, 1, 1'b0, 1'b0, 1'b0);
    run(4096, 2, 1'b0, 1'b0, 1'b0);
    run(2049, 3, 1'b0, 1'b0, 1'b0);
    data_valid = 1'b1;
    data = word(4, 0);
    run(0, 4, 1'b0, 1'b0, 1'b0);
    run(80, 5, 1'b1, 1'b1, 1'b0);
`ifdef AXIS_WDATA_BRESP_EN
    bresp_q.push_back(2'b10);
    bresp_q.push_back(2'b00);
    run(2049, 6, 1'b0, 1'b0, 1'b1);
`endif

    // Abort a 512-beat run after 100 beats.
    for (int i = 0; i < 512; i++) begin
      beat_t b;
      b.data = word(7, i);
      b.last = ((i % BURST_LENGTH) == BURST_LENGTH - 1) || (i == 511);
      exp_q.push_back(b);
    end
    fired = 0; wlast_cnt = 0;
    cfg_length = 32'd4096;
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    send_words(7, 512, 1'b0, 1'b0, 100);
    check("abort_beats", DW'(fired), DW'(100));
    check("abort_no_wlast", DW'(wlast_cnt), DW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    #1;
    check("abort_idle", DW'(cfg_ready), DW'(1'b1));
    check("abort_wvalid", DW'(axi_wvalid), DW'(1'b0));
    check("abort_data_ready", DW'(data_ready), DW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    data_valid = 1'b0;
    exp_q.delete();
    bresp_q.delete();
    @(negedge clk);
    run(16, 8, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
